// File: rtl/ctrl_decoder.sv
// Main control decoder for the 8-opcode accumulator/register CPU: zero-latency
// decode, a registered copy for writeback, and the two-cycle swp sequencer.
module ctrl_decoder #(
    parameter int OP_W = 3,
    parameter int WS_W = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [OP_W-1:0] Op,
    input  logic            InstValid,
    output logic [WS_W-1:0] WriteSrc,
    output logic            ALUOp,
    output logic            MemWrite,
    output logic            BranchEn,
    output logic            RegWrite,
    output logic            Stall,
    output logic            SwapPhase,
    output logic [WS_W-1:0] WriteSrc_q,
    output logic            ALUOp_q,
    output logic            MemWrite_q,
    output logic            BranchEn_q,
    output logic            RegWrite_q
);

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LWD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SWD = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SLT = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BEQ = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SWP = OP_W'(6);
    localparam logic [OP_W-1:0] OP_LIM = OP_W'(7);

    localparam logic [WS_W-1:0] WS_ALU   = WS_W'(0);
    localparam logic [WS_W-1:0] WS_MEM   = WS_W'(1);
    localparam logic [WS_W-1:0] WS_CMP   = WS_W'(2);
    localparam logic [WS_W-1:0] WS_OTHER = WS_W'(3);

    typedef enum logic {
        IDLE  = 1'b0,
        SWAP2 = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [WS_W-1:0] ws_raw;
    logic            alu_raw, mw_raw, be_raw, rw_raw, is_swp, issue;

    logic [WS_W-1:0] write_src_d, write_src_q;
    logic            alu_op_d, alu_op_q;
    logic            mem_write_d, mem_write_q;
    logic            branch_en_d, branch_en_q;
    logic            reg_write_d, reg_write_q;

    // Raw table decode; unknown opcodes fall through to the safe default.
    always_comb begin
        ws_raw  = WS_OTHER;
        alu_raw = 1'b0;
        mw_raw  = 1'b0;
        be_raw  = 1'b0;
        rw_raw  = 1'b0;
        is_swp  = 1'b0;
        if (state_q == SWAP2) begin
            rw_raw = 1'b1;
        end else begin
            case (Op)
                OP_ADD: begin ws_raw = WS_ALU; rw_raw = 1'b1; end
                OP_SUB: begin ws_raw = WS_ALU; alu_raw = 1'b1; rw_raw = 1'b1; end
                OP_LWD: begin ws_raw = WS_MEM; rw_raw = 1'b1; end
                OP_SWD: mw_raw = 1'b1;
                OP_SLT: begin ws_raw = WS_CMP; rw_raw = 1'b1; end
                OP_BEQ: begin alu_raw = 1'b1; be_raw = 1'b1; end
                OP_SWP: begin rw_raw = 1'b1; is_swp = 1'b1; end
                OP_LIM: rw_raw = 1'b1;
                default: ;
            endcase
        end
    end

    // Side-effecting enables are gated by valid and reset; the second swp
    // write is already committed, so it ignores InstValid.
    always_comb begin
        issue     = InstValid & ~Reset;
        WriteSrc  = ws_raw;
        ALUOp     = alu_raw;
        MemWrite  = mw_raw & issue;
        BranchEn  = be_raw & issue;
        RegWrite  = rw_raw & ((state_q == SWAP2) ? ~Reset : issue);
        Stall     = is_swp & issue;
        SwapPhase = (state_q == SWAP2);
        state_d   = Stall ? SWAP2 : IDLE;
    end

    always_comb begin
        write_src_d = WriteSrc;
        alu_op_d    = ALUOp;
        mem_write_d = MemWrite;
        branch_en_d = BranchEn;
        reg_write_d = RegWrite;
    end

    // Stage boundary: swp sequencer and writeback copy of the controls.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            write_src_q <= '0;
            alu_op_q    <= 1'b0;
            mem_write_q <= 1'b0;
            branch_en_q <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_src_q <= write_src_d;
            alu_op_q    <= alu_op_d;
            mem_write_q <= mem_write_d;
            branch_en_q <= branch_en_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign WriteSrc_q = write_src_q;
    assign ALUOp_q    = alu_op_q;
    assign MemWrite_q = mem_write_q;
    assign BranchEn_q = branch_en_q;
    assign RegWrite_q = reg_write_q;

endmodule

// File: tb/tb_ctrl_decoder.sv
// Directed-vector bench for ctrl_decoder: decode table, gating, async reset,
// registered copy and the swp sequencer.
`timescale 1ns/1ps
module tb_ctrl_decoder;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [2:0] Op;
    logic       InstValid;
    logic [1:0] WriteSrc, WriteSrc_q;
    logic       ALUOp, MemWrite, BranchEn, RegWrite, Stall, SwapPhase;
    logic       ALUOp_q, MemWrite_q, BranchEn_q, RegWrite_q;

    int n_cmp = 0;
    int n_bad = 0;

    ctrl_decoder #(.OP_W(3), .WS_W(2)) dut (
        .Clk(Clk), .Reset(Reset), .Op(Op), .InstValid(InstValid),
        .WriteSrc(WriteSrc), .ALUOp(ALUOp), .MemWrite(MemWrite),
        .BranchEn(BranchEn), .RegWrite(RegWrite), .Stall(Stall),
        .SwapPhase(SwapPhase), .WriteSrc_q(WriteSrc_q), .ALUOp_q(ALUOp_q),
        .MemWrite_q(MemWrite_q), .BranchEn_q(BranchEn_q), .RegWrite_q(RegWrite_q)
    );

    always #5 Clk = ~Clk;

    logic [5:0] comb_bus, q_bus;
    assign comb_bus = {WriteSrc, ALUOp, MemWrite, BranchEn, RegWrite};
    assign q_bus    = {WriteSrc_q, ALUOp_q, MemWrite_q, BranchEn_q, RegWrite_q};

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // {WriteSrc, ALUOp, MemWrite, BranchEn, RegWrite}
    function automatic logic [5:0] dec_model(input logic [2:0] op, input logic valid);
        logic [5:0] r;
        case (op)
            3'd0: r = 6'b00_0001;
            3'd1: r = 6'b00_1001;
            3'd2: r = 6'b01_0001;
            3'd3: r = 6'b11_0100;
            3'd4: r = 6'b10_0001;
            3'd5: r = 6'b11_1010;
            3'd6: r = 6'b11_0001;
            default: r = 6'b11_0001;
        endcase
        if (!valid) r = r & 6'b111000;
        return r;
    endfunction

    initial begin
        logic [5:0] e;
        Reset = 1'b1; InstValid = 1'b1; Op = 3'b011;
        #1;
        chk("rst_comb", 8'(comb_bus), 8'(6'b11_0000));
        chk("rst_q", 8'(q_bus), 8'd0);
        chk("rst_stall", 8'(Stall), 8'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Table sweep; swp is issued without valid at the edge so the FSM stays idle.
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            Op = i[2:0]; InstValid = 1'b1;
            #1;
            chk("dec", 8'(comb_bus), 8'(dec_model(i[2:0], 1'b1)));
            chk("dec_stall", 8'(Stall), 8'(i == 6));
            if (i == 6) InstValid = 1'b0;
            @(posedge Clk); #1;
            chk("dec_q", 8'(q_bus), 8'(dec_model(i[2:0], i != 6)));
            chk("dec_phase", 8'(SwapPhase), 8'd0);
        end

        // Async reset mid-cycle while a store is decoded.
        @(negedge Clk);
        Op = 3'b011; InstValid = 1'b1;
        @(posedge Clk); #1;
        chk("swd_q", 8'(q_bus), 8'(6'b11_0100));
        #2 Reset = 1'b1;
        #1;
        chk("arst_mw", 8'(MemWrite), 8'd0);
        chk("arst_q", 8'(q_bus), 8'd0);
        chk("arst_comb", 8'(comb_bus), 8'(6'b11_0000));
        @(negedge Clk);
        Reset = 1'b0;

        // Load, then drop valid.
        @(negedge Clk);
        Op = 3'b010; InstValid = 1'b1;
        @(posedge Clk); #1;
        chk("lwd_ws_q", 8'(WriteSrc_q), 8'(2'b01));
        chk("lwd_rw_q", 8'(RegWrite_q), 8'd1);
        InstValid = 1'b0;
        #1;
        chk("inv_rw", 8'(RegWrite), 8'd0);
        chk("inv_ws", 8'(WriteSrc), 8'(2'b01));

        // Two-cycle swp with a different opcode arriving in the second cycle.
        @(negedge Clk);
        Op = 3'b110; InstValid = 1'b1;
        #1;
        chk("swp1_stall", 8'(Stall), 8'd1);
        chk("swp1_phase", 8'(SwapPhase), 8'd0);
        chk("swp1_rw", 8'(RegWrite), 8'd1);
        @(posedge Clk); #1;
        Op = 3'b011;
        #1;
        chk("swp2_phase", 8'(SwapPhase), 8'd1);
        chk("swp2_comb", 8'(comb_bus), 8'(6'b11_0001));
        chk("swp2_stall", 8'(Stall), 8'd0);
        chk("swp2_q", 8'(q_bus), 8'(6'b11_0001));
        @(posedge Clk); #1;
        chk("swp3_phase", 8'(SwapPhase), 8'd0);
        chk("swp3_comb", 8'(comb_bus), 8'(6'b11_0100));
        chk("swp3_stall", 8'(Stall), 8'd0);
        chk("swp3_q", 8'(q_bus), 8'(6'b11_0001));

        // Reset pulse during the second swp cycle.
        @(negedge Clk);
        Op = 3'b110;
        @(posedge Clk); #1;
        chk("rswp_phase", 8'(SwapPhase), 8'd1);
        #2 Reset = 1'b1; Op = 3'b000;
        #1;
        chk("rswp_rst_phase", 8'(SwapPhase), 8'd0);
        chk("rswp_rst_stall", 8'(Stall), 8'd0);
        chk("rswp_rst_rw", 8'(RegWrite), 8'd0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("rswp_rel_phase", 8'(SwapPhase), 8'd0);
        chk("rswp_rel_stall", 8'(Stall), 8'd0);
        @(posedge Clk); #1;
        chk("rswp_idle", 8'(SwapPhase), 8'd0);
        chk("rswp_add", 8'(comb_bus), 8'(6'b00_0001));

        // Partially unknown opcode.
        @(negedge Clk);
        Op = 3'bx1x; InstValid = 1'b1;
        #1;
        if ($isunknown(Op)) e = 6'b11_0000;
        else e = dec_model(Op, 1'b1);
        chk("xop", 8'(comb_bus), 8'(e));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_decoder.md
Name: ctrl_decoder

Overview:
Main control decoder for the 8-opcode accumulator/register CPU. It maps the 3-bit opcode to datapath control signals, with zero latency so the single-cycle datapath can use them in the same cycle. It also provides a registered copy of the controls for the writeback/pipeline stage and a small FSM that sequences the two-cycle swp instruction. It sits between the instruction ROM/decoder and the ALU, register file, data memory and PC logic.

Parameters:
OP_W, 3, opcode width (fixed; the decode table assumes 3).
WS_W, 2, WriteSrc select width.

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
Op  input  3  current instruction opcode.
InstValid  input  1  high when Op holds a real instruction this cycle.
WriteSrc  output  2  register-write data select: 00 ALU, 01 memory, 10 compare (slt), 11 other/none.
ALUOp  output  1  0 = add, 1 = subtract.
MemWrite  output  1  data-memory write enable.
BranchEn  output  1  branch-if-equal enable to PC logic.
RegWrite  output  1  register-file write enable.
Stall  output  1  holds the PC (first cycle of swp).
SwapPhase  output  1  0 = first swp write, 1 = second swp write.
WriteSrc_q, ALUOp_q, MemWrite_q, BranchEn_q, RegWrite_q  output  2/1/1/1/1  registered copies.

Behaviour:
- Combinational decode, valid in the same cycle as Op with no clock needed. Columns are WriteSrc, ALUOp, MemWrite, BranchEn, RegWrite:
  000 add: 00,0,0,0,1
  001 sub: 00,1,0,0,1
  010 lwd: 01,0,0,0,1
  011 swd: 11,0,1,0,0
  100 slt: 10,0,0,0,1
  101 beq: 11,1,0,1,0 (subtract for compare)
  110 swp: 11,0,0,0,1
  111 lim: 11,0,0,0,1
- Op with X/Z bits: outputs take the safe default 11,0,0,0,0.
- InstValid low: MemWrite, BranchEn, RegWrite and Stall forced to 0. WriteSrc and ALUOp still follow the table.
- Reset high: MemWrite, BranchEn, RegWrite and Stall forced to 0 combinationally. All registers clear immediately and asynchronously.
- swp FSM, with states IDLE and SWAP2:
  - IDLE + Op=110 + InstValid: Stall=1, SwapPhase=0; next state SWAP2.
  - SWAP2: Stall=0, SwapPhase=1. RegWrite=1 and decode stays as swp regardless of Op; next state IDLE.
  - Every other case stays in IDLE with SwapPhase=0.
  - Reset mid-swp returns the FSM to IDLE.
- Registered outputs take the combinational values on every rising Clk, giving one-cycle latency. Reset value is 00,0,0,0,0.
- Only one of MemWrite, BranchEn, RegWrite is ever high in a cycle.

Test Plan:
- Reset=0, InstValid=1; sweep Op 000..111, checking 1 time unit after each change -> the eight table rows exactly (e.g. 011 -> 11,0,1,0,0; 101 -> 11,1,0,1,0).
- Assert Reset asynchronously mid-cycle while Op=011 -> MemWrite=0 and all _q outputs 0 immediately, before any clock edge.
- Op=010, InstValid=1, one clock -> WriteSrc_q=01, RegWrite_q=1. Set InstValid=0 -> RegWrite=0 while WriteSrc stays 01.
- Op=110 at edge N -> Stall=1 in cycle N. At N+1, Op changed to 011 -> SwapPhase=1, RegWrite=1, MemWrite=0, Stall=0. At N+2 the FSM is in IDLE.
- Op=110, then Reset pulse during SWAP2 -> FSM in IDLE, SwapPhase=0, Stall=0 after release.
- Op driven to 3'bx1x -> safe default 11,0,0,0,0.
